median_window_ctrl: RTL and testbench
=====================================

# median_window_ctrl

Sequencer that sits in front of the 3x3 median sort tree and turns a raster pixel stream into the nine window taps and three aligned timing strobes the tree consumes. It keeps two internal line buffers and tracks column and row position using href, clken and vsync. It replicates edge pixels at the top and left borders, and it can bypass windowing so that all nine taps carry the current pixel. Its outputs feed the median filter's data11..data33 and its vsync/href/clken inputs directly.

## Interface
- IMG_WIDTH, 640, active pixels per line; line buffer depth.
- IMG_HEIGHT, 480, active lines per frame; row counter limit.
- DATA_W, 8, pixel width.
- clk  in  1  pixel clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- per_frame_vsync  in  1  frame sync, high during frame.
- per_frame_href  in  1  line valid.
- per_frame_clken  in  1  pixel valid qualifier (may have gaps inside href).
- per_img_data  in  DATA_W  input pixel.
- bypass  in  1  1 = all nine taps equal current pixel; sampled per pixel.
- matrix_frame_vsync / matrix_frame_href / matrix_frame_clken  out  1 each  input strobes delayed 2 clk.
- matrix_p11..matrix_p33  out  DATA_W each  window taps; row 1 = two lines up, row 3 = current line; column 1 = two pixels left, column 3 = current pixel.
- frame_done  out  1  one-cycle pulse on the vsync falling edge.

## Operation
- Column counter col (clog2(IMG_WIDTH) bits):
  - increments on each clken while href=1;
  - clears to 0 on the href falling edge;
  - saturates at IMG_WIDTH-1. Extra pixels still produce output but do not write the line buffers.
- Row counter row:
  - increments on the href falling edge;
  - clears on the vsync rising edge;
  - saturates at IMG_HEIGHT-1.
- Stage 1, on clken && href:
  - synchronous read of buf1[col] and buf2[col];
  - write per_img_data into buf1[col], and the old buf1[col] into buf2[col];
  - read-before-write: the reads return pre-write contents.
  - Register the pixel, col, row and bypass.
- Row selection:
  - cur = registered pixel;
  - mid = (row>=1) ? buf1 read : cur;
  - top = (row>=2) ? buf2 read : mid.
- Stage 2, on a stage-1 valid: shift each row through a 3-deep column register (tap3 <= new, tap2 <= tap3, tap1 <= tap2).
- Column border:
  - at col==0, all three taps of each row load the new value;
  - at col==1, tap1 and tap2 both load the old tap3.
- Bypass: all nine outputs = cur.
- When no pixel is valid, the taps hold their values.
- Line buffers are never cleared. Row-border replication masks stale contents.

## Timing
- Strobe latency is exactly 2 clk. The matrix_frame_* signals are per_frame_* passed through two flops with no qualification.
- Taps are valid in the cycle where matrix_frame_clken=1, corresponding to the pixel presented 2 clk earlier.
- Throughput is one pixel per clk. Clken gaps of any length are tolerated.
- frame_done asserts 1 clk after the vsync falling edge is sampled.
- Edge cases:
  - Simultaneous vsync rise and href fall: the row clear wins.
  - href falling in the same cycle as the last clken: that pixel is processed before col clears.
- Reset (asynchronous, any time, including mid-line):
  - all outputs go to 0;
  - col, row and the pipeline go to 0;
  - the first line after reset is treated as row 0.

## Test plan
- Reset mid-line:
  - assert rst while href=1 and col=100;
  - all outputs 0 on the next clk edge;
  - the next frame's first line shows top=mid=cur replication.
- Ramp frame, IMG_WIDTH=8, IMG_HEIGHT=4, pixel = 16*row + col:
  - at row 2, col 5 the outputs are p11..p13 = 3,4,5; p21..p23 = 19,20,21; p31..p33 = 35,36,37;
  - each appears 2 clk after the input.
- Left/top border:
  - row 0, col 0, pixel 0x40: all nine taps = 0x40;
  - row 1, col 1: p21 = p22 = buf1 value at col 0, and p11..p13 = p21..p23.
- Clken gaps: random 0–3 idle cycles between pixels produce the same tap sequence as the gap-free ramp, and the taps hold during gaps.
- Bypass toggled at col 4 with pixel 0x7F: all taps = 0x7F for that pixel, and normal windowing resumes on the next pixel.
- Overlength line of 10 pixels with IMG_WIDTH=8: cols 8 and 9 do not corrupt buf1[7]; the next row reads the correct value at col 7; frame_done pulses once per frame.

Source files
------------

// File: rtl/median_window_ctrl.sv
// Window sequencer for the 3x3 median sort tree: turns a raster pixel stream into
// nine window taps plus 2-clk-aligned timing strobes, with top/left edge replication.
module median_window_ctrl #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_data,
    input  logic              bypass,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33,
    output logic              frame_done
);

    localparam int unsigned COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 4) ? $clog2(IMG_HEIGHT) : 2;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

    typedef logic [2:0][DATA_W-1:0] win_row_t;

    logic vs_d1, hs_d1, ce_d1;
    logic pix_valid_c, href_fall_c, vsync_rise_c, vsync_fall_c, wr_en_c;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             line_full;

    logic [DATA_W-1:0] buf1 [IMG_WIDTH];
    logic [DATA_W-1:0] buf2 [IMG_WIDTH];

    logic              s1_valid, s1_byp;
    logic [DATA_W-1:0] s1_pix, rd1, rd2;
    logic [COL_W-1:0]  s1_col;
    logic [ROW_W-1:0]  s1_row;

    logic [DATA_W-1:0] cur_c, mid_c, top_c;
    win_row_t win_top, win_mid, win_cur;
    win_row_t top_win_c, mid_win_c, cur_win_c;

    assign pix_valid_c  = per_frame_clken & per_frame_href;
    assign href_fall_c  = hs_d1 & ~per_frame_href;
    assign vsync_rise_c = ~vs_d1 & per_frame_vsync;
    assign vsync_fall_c = vs_d1 & ~per_frame_vsync;
    assign wr_en_c      = pix_valid_c & ~line_full;

    // Strobe delay line and end-of-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d1              <= 1'b0;
            hs_d1              <= 1'b0;
            ce_d1              <= 1'b0;
            matrix_frame_vsync <= 1'b0;
            matrix_frame_href  <= 1'b0;
            matrix_frame_clken <= 1'b0;
            frame_done         <= 1'b0;
        end else begin
            vs_d1              <= per_frame_vsync;
            hs_d1              <= per_frame_href;
            ce_d1              <= per_frame_clken;
            matrix_frame_vsync <= vs_d1;
            matrix_frame_href  <= hs_d1;
            matrix_frame_clken <= ce_d1;
            frame_done         <= vsync_fall_c;
        end
    end

    // Raster position; line_full stops pixels past the last column from writing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            line_full <= 1'b0;
            row       <= '0;
        end else begin
            if (href_fall_c) begin
                col       <= '0;
                line_full <= 1'b0;
            end else if (pix_valid_c) begin
                if (col == COL_MAX) begin
                    line_full <= 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (vsync_rise_c) begin
                row <= '0;
            end else if (href_fall_c && (row != ROW_MAX)) begin
                row <= row + 1'b1;
            end
        end
    end

    // Line buffer storage; contents are never cleared
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            buf1[col] <= per_img_data;
            buf2[col] <= buf1[col];
        end
    end

    // Stage 1: read-before-write line buffer access and pixel capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_byp   <= 1'b0;
            s1_pix   <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
            rd1      <= '0;
            rd2      <= '0;
        end else begin
            s1_valid <= pix_valid_c;
            if (pix_valid_c) begin
                s1_byp <= bypass;
                s1_pix <= per_img_data;
                s1_col <= col;
                s1_row <= row;
                rd1    <= buf1[col];
                rd2    <= buf2[col];
            end
        end
    end

    // Column shift with left-border replication; index 2 is the newest column
    function automatic win_row_t shift_row(input win_row_t taps,
                                           input logic [DATA_W-1:0] nv,
                                           input logic [COL_W-1:0] c);
        win_row_t r;
        if (c == '0) begin
            r = {nv, nv, nv};
        end else if (c == COL_W'(1)) begin
            r = {nv, taps[2], taps[2]};
        end else begin
            r = {nv, taps[2], taps[1]};
        end
        return r;
    endfunction

    // Top-border replication hides stale line buffer contents
    always_comb begin
        cur_c     = s1_pix;
        mid_c     = (s1_row >= ROW_W'(1)) ? rd1 : cur_c;
        top_c     = (s1_row >= ROW_W'(2)) ? rd2 : mid_c;
        top_win_c = shift_row(win_top, top_c, s1_col);
        mid_win_c = shift_row(win_mid, mid_c, s1_col);
        cur_win_c = shift_row(win_cur, cur_c, s1_col);
    end

    // Stage 2: window registers keep true history; bypass only overrides the taps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_top    <= '0;
            win_mid    <= '0;
            win_cur    <= '0;
            matrix_p11 <= '0;
            matrix_p12 <= '0;
            matrix_p13 <= '0;
            matrix_p21 <= '0;
            matrix_p22 <= '0;
            matrix_p23 <= '0;
            matrix_p31 <= '0;
            matrix_p32 <= '0;
            matrix_p33 <= '0;
        end else if (s1_valid) begin
            win_top <= top_win_c;
            win_mid <= mid_win_c;
            win_cur <= cur_win_c;
            if (s1_byp) begin
                matrix_p11 <= cur_c;
                matrix_p12 <= cur_c;
                matrix_p13 <= cur_c;
                matrix_p21 <= cur_c;
                matrix_p22 <= cur_c;
                matrix_p23 <= cur_c;
                matrix_p31 <= cur_c;
                matrix_p32 <= cur_c;
                matrix_p33 <= cur_c;
            end else begin
                matrix_p11 <= top_win_c[0];
                matrix_p12 <= top_win_c[1];
                matrix_p13 <= top_win_c[2];
                matrix_p21 <= mid_win_c[0];
                matrix_p22 <= mid_win_c[1];
                matrix_p23 <= mid_win_c[2];
                matrix_p31 <= cur_win_c[0];
                matrix_p32 <= cur_win_c[1];
                matrix_p33 <= cur_win_c[2];
            end
        end
    end

endmodule

// File: tb/tb_median_window_ctrl.sv
// Bench for median_window_ctrl: random and ramp frames checked against a frame-image
// model that derives each window from clamped row/column neighbours.
module tb_median_window_ctrl;

    localparam int W = 8;
    localparam int H = 4;

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       ce;
        logic [7:0] d;
        logic       byp;
        logic [3:0] r;
        logic [3:0] c;
    } stim_t;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        ce;
        logic        fd;
        logic        pix;
        logic        chk;
        logic [3:0]  r;
        logic [3:0]  c;
        logic [71:0] taps;
    } exp_t;

    logic clk, rst;
    logic vsync, href, clken, byp;
    logic [7:0] din;
    logic mvs, mhs, mce, frame_done;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic [71:0] taps;

    assign taps = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

    median_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_data(din), .bypass(byp),
        .matrix_frame_vsync(mvs), .matrix_frame_href(mhs), .matrix_frame_clken(mce),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    stim_t q[$];
    logic [7:0] img [4][10];
    exp_t pipe0, pipe1, exp_now;
    logic fd_now;
    logic [71:0] held;
    logic known, last_vs;

    // Window of pixel (r,c): rows/cols above and left are clamped to the frame edge
    function automatic logic [71:0] model_taps(input int r, input int c);
        int rows[3];
        int cols[3];
        logic [71:0] t;
        rows[2] = r;
        rows[1] = (r >= 1) ? r - 1 : r;
        rows[0] = (r >= 2) ? r - 2 : rows[1];
        cols[2] = c;
        cols[1] = (c >= 1) ? c - 1 : 0;
        cols[0] = (c >= 2) ? c - 2 : 0;
        t = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                t = (t << 8) | 72'(img[rows[i]][cols[j]]);
        return t;
    endfunction

    function automatic void build_frame(input int len, input int gap_max, input bit ramp,
                                        input int ovr_r, input int ovr_c,
                                        input logic [7:0] ovr_v, input logic ovr_byp);
        stim_t s;
        for (int k = 0; k < 2; k++) begin
            s = '0; s.vs = 1'b1; s.d = 8'($urandom); q.push_back(s);
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < len; c++) begin
                if (c > 0) begin
                    int g;
                    g = int'($urandom_range(gap_max, 0));
                    for (int k = 0; k < g; k++) begin
                        s = '0; s.vs = 1'b1; s.hs = 1'b1; s.d = 8'($urandom); q.push_back(s);
                    end
                end
                s = '0; s.vs = 1'b1; s.hs = 1'b1; s.ce = 1'b1;
                s.d = ramp ? 8'(16 * r + c) : 8'($urandom);
                if (r == ovr_r && c == ovr_c) begin
                    s.d = ovr_v;
                    s.byp = ovr_byp;
                end
                s.r = 4'(r); s.c = 4'(c);
                q.push_back(s);
            end
            for (int k = 0; k < 2; k++) begin
                s = '0; s.vs = 1'b1; q.push_back(s);
            end
        end
        for (int k = 0; k < 3; k++) begin
            s = '0; q.push_back(s);
        end
    endfunction

    task automatic reset_model();
        pipe0 = '0; pipe1 = '0; exp_now = '0; fd_now = 1'b0;
        held = '0; known = 1'b1; last_vs = 1'b0;
    endtask

    // One clock: retire the expectation for outputs now visible, then apply s
    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        fd_now  = pipe0.fd;
        exp_now = pipe1;
        pipe1   = pipe0;
        e = '0;
        e.vs = s.vs; e.hs = s.hs; e.ce = s.ce; e.r = s.r; e.c = s.c;
        e.fd = last_vs & ~s.vs;
        last_vs = s.vs;
        if (s.ce && s.hs) begin
            img[int'(s.r)][int'(s.c)] = s.d;
            e.pix = 1'b1;
            if (int'(s.c) >= W) begin
                known = 1'b0;
            end else begin
                held  = s.byp ? {9{s.d}} : model_taps(int'(s.r), int'(s.c));
                known = 1'b1;
            end
        end
        e.taps = held;
        e.chk  = known;
        pipe0  = e;
        vsync = s.vs; href = s.hs; clken = s.ce; din = s.d; byp = s.byp;
    endtask

    task automatic test_reset();
        rst = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; din = '0; byp = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({taps, mvs, mhs, mce, frame_done} !== 76'd0) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0", {taps, mvs, mhs, mce, frame_done});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_ramp();
        q.delete();
        build_frame(W, 0, 1'b1, -1, -1, 8'h00, 1'b0);
        foreach (q[i]) begin
            step(q[i]);
            checks++;
            if ({mvs, mhs, mce} !== {exp_now.vs, exp_now.hs, exp_now.ce}) begin
                errors++;
                $display("FAIL ramp strobes: got %b expected %b", {mvs, mhs, mce}, {exp_now.vs, exp_now.hs, exp_now.ce});
            end
            if (exp_now.chk) begin
                checks++;
                if (taps !== exp_now.taps) begin
                    errors++;
                    $display("FAIL ramp taps r%0d c%0d: got %h expected %h", exp_now.r, exp_now.c, taps, exp_now.taps);
                end
            end
            checks++;
            if (frame_done !== fd_now) begin
                errors++;
                $display("FAIL ramp frame_done: got %b expected %b", frame_done, fd_now);
            end
            if (exp_now.pix && exp_now.r == 4'd2 && exp_now.c == 4'd5) begin
                checks++;
                if (taps !== 72'h03_04_05_13_14_15_23_24_25) begin
                    errors++;
                    $display("FAIL ramp r2c5 window: got %h expected 030405131415232425", taps);
                end
            end
        end
    endtask

    task automatic test_border();
        q.delete();
        build_frame(W, 0, 1'b0, 0, 0, 8'h40, 1'b0);
        foreach (q[i]) begin
            step(q[i]);
            checks++;
            if ({mvs, mhs, mce} !== {exp_now.vs, exp_now.hs, exp_now.ce}) begin
                errors++;
                $display("FAIL border strobes: got %b expected %b", {mvs, mhs, mce}, {exp_now.vs, exp_now.hs, exp_now.ce});
            end
            if (exp_now.chk) begin
                checks++;
                if (taps !== exp_now.taps) begin
                    errors++;
                    $display("FAIL border taps r%0d c%0d: got %h expected %h", exp_now.r, exp_now.c, taps, exp_now.taps);
                end
            end
            checks++;
            if (frame_done !== fd_now) begin
                errors++;
                $display("FAIL border frame_done: got %b expected %b", frame_done, fd_now);
            end
            if (exp_now.pix && exp_now.r == 4'd0 && exp_now.c == 4'd0) begin
                checks++;
                if (taps !== {9{8'h40}}) begin
                    errors++;
                    $display("FAIL border corner: got %h expected all 40", taps);
                end
            end
            if (exp_now.pix && exp_now.r == 4'd1 && exp_now.c == 4'd1) begin
                checks++;
                if ({p21, p22} !== 16'h4040) begin
                    errors++;
                    $display("FAIL border r1c1 p21/p22: got %h expected 4040", {p21, p22});
                end
            end
        end
    endtask

    task automatic test_clken_gaps();
        q.delete();
        build_frame(W, 3, 1'b1, -1, -1, 8'h00, 1'b0);
        foreach (q[i]) begin
            step(q[i]);
            checks++;
            if ({mvs, mhs, mce} !== {exp_now.vs, exp_now.hs, exp_now.ce}) begin
                errors++;
                $display("FAIL gaps strobes: got %b expected %b", {mvs, mhs, mce}, {exp_now.vs, exp_now.hs, exp_now.ce});
            end
            if (exp_now.chk) begin
                checks++;
                if (taps !== exp_now.taps) begin
                    errors++;
                    $display("FAIL gaps taps r%0d c%0d: got %h expected %h", exp_now.r, exp_now.c, taps, exp_now.taps);
                end
            end
            checks++;
            if (frame_done !== fd_now) begin
                errors++;
                $display("FAIL gaps frame_done: got %b expected %b", frame_done, fd_now);
            end
        end
    endtask

    task automatic test_bypass();
        q.delete();
        build_frame(W, 1, 1'b0, 1, 4, 8'h7F, 1'b1);
        foreach (q[i]) begin
            step(q[i]);
            checks++;
            if ({mvs, mhs, mce} !== {exp_now.vs, exp_now.hs, exp_now.ce}) begin
                errors++;
                $display("FAIL bypass strobes: got %b expected %b", {mvs, mhs, mce}, {exp_now.vs, exp_now.hs, exp_now.ce});
            end
            if (exp_now.chk) begin
                checks++;
                if (taps !== exp_now.taps) begin
                    errors++;
                    $display("FAIL bypass taps r%0d c%0d: got %h expected %h", exp_now.r, exp_now.c, taps, exp_now.taps);
                end
            end
            checks++;
            if (frame_done !== fd_now) begin
                errors++;
                $display("FAIL bypass frame_done: got %b expected %b", frame_done, fd_now);
            end
            if (exp_now.pix && exp_now.r == 4'd1 && exp_now.c == 4'd4) begin
                checks++;
                if (taps !== {9{8'h7F}}) begin
                    errors++;
                    $display("FAIL bypass pixel: got %h expected all 7f", taps);
                end
            end
        end
    endtask

    task automatic test_overlength();
        int fd_seen;
        fd_seen = 0;
        q.delete();
        build_frame(W + 2, 0, 1'b0, -1, -1, 8'h00, 1'b0);
        foreach (q[i]) begin
            step(q[i]);
            if (frame_done === 1'b1) fd_seen++;
            checks++;
            if ({mvs, mhs, mce} !== {exp_now.vs, exp_now.hs, exp_now.ce}) begin
                errors++;
                $display("FAIL overlength strobes: got %b expected %b", {mvs, mhs, mce}, {exp_now.vs, exp_now.hs, exp_now.ce});
            end
            if (exp_now.chk) begin
                checks++;
                if (taps !== exp_now.taps) begin
                    errors++;
                    $display("FAIL overlength taps r%0d c%0d: got %h expected %h", exp_now.r, exp_now.c, taps, exp_now.taps);
                end
            end
            checks++;
            if (frame_done !== fd_now) begin
                errors++;
                $display("FAIL overlength frame_done: got %b expected %b", frame_done, fd_now);
            end
        end
        checks++;
        if (fd_seen !== 1) begin
            errors++;
            $display("FAIL overlength frame_done count: got %0d expected 1", fd_seen);
        end
    endtask

    task automatic test_reset_midline();
        q.delete();
        build_frame(W, 0, 1'b0, -1, -1, 8'h00, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i]);
            if (exp_now.chk) begin
                checks++;
                if (taps !== exp_now.taps) begin
                    errors++;
                    $display("FAIL premid taps r%0d c%0d: got %h expected %h", exp_now.r, exp_now.c, taps, exp_now.taps);
                end
            end
            if (q[i].ce && q[i].r == 4'd2 && q[i].c == 4'd5) break;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({taps, mvs, mhs, mce, frame_done} !== 76'd0) begin
            errors++;
            $display("FAIL midline reset async: got %h expected 0", {taps, mvs, mhs, mce, frame_done});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({taps, mvs, mhs, mce, frame_done} !== 76'd0) begin
            errors++;
            $display("FAIL midline reset edge: got %h expected 0", {taps, mvs, mhs, mce, frame_done});
        end
        @(negedge clk);
        vsync = 1'b0; href = 1'b0; clken = 1'b0; byp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        q.delete();
        build_frame(W, 2, 1'b0, -1, -1, 8'h00, 1'b0);
        foreach (q[i]) begin
            step(q[i]);
            checks++;
            if ({mvs, mhs, mce} !== {exp_now.vs, exp_now.hs, exp_now.ce}) begin
                errors++;
                $display("FAIL postreset strobes: got %b expected %b", {mvs, mhs, mce}, {exp_now.vs, exp_now.hs, exp_now.ce});
            end
            if (exp_now.chk) begin
                checks++;
                if (taps !== exp_now.taps) begin
                    errors++;
                    $display("FAIL postreset taps r%0d c%0d: got %h expected %h", exp_now.r, exp_now.c, taps, exp_now.taps);
                end
            end
            checks++;
            if (frame_done !== fd_now) begin
                errors++;
                $display("FAIL postreset frame_done: got %b expected %b", frame_done, fd_now);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_border();
        test_clken_gaps();
        test_bypass();
        test_overlength();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
